// File: rtl/capture_buffer_if.sv
// rtl/capture_buffer_if.sv - capture input and drain handshake bundle for capture_buffer
interface capture_buffer_if;
  logic [7:0] cap_data;
  logic       cap_strb;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  // Producer/consumer side: feeds captures in and accepts drained bytes
  modport master (
    output cap_data, cap_strb, rd_ready,
    input  rd_data, rd_valid
  );

  // Buffer side
  modport slave (
    input  cap_data, cap_strb, rd_ready,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - circular capture FIFO with FWFT drain, overflow tracking; CAPTURE_BUFFER_TSTAMP_EN adds timestamps
module capture_buffer #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter bit EDGE_MODE = 1'b1,
  parameter int DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  capture_buffer_if.slave   bus,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [DROP_W-1:0] drop_cnt
`ifdef CAPTURE_BUFFER_TSTAMP_EN
  ,
  output logic [15:0]       rd_tstamp
`endif
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       level_q;
  logic [AW:0]       level_nxt;
  logic              full_q;
  logic              empty_q;
  logic              valid_q;
  logic              strb_q;
  logic              ovf_q;
  logic [DROP_W-1:0] drop_q;
  logic              cap_ev;
  logic              pop;
  logic              wr;
  logic              drop;

  // Capture qualification, handshake decode and next fill level
  always_comb begin
    cap_ev    = bus.cap_strb && (!EDGE_MODE || !strb_q);
    pop       = valid_q && bus.rd_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts
    wr        = cap_ev && (!full_q || pop);
    drop      = cap_ev && full_q && !pop;
    level_nxt = level_q;
    if (wr && !pop)
      level_nxt = level_q + (AW+1)'(1);
    else if (pop && !wr)
      level_nxt = level_q - (AW+1)'(1);
  end

  // Pointers, fill level and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
      strb_q  <= 1'b0;
    end else begin
      strb_q  <= bus.cap_strb;
      if (wr)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      level_q <= level_nxt;
      full_q  <= (level_nxt == DEPTH_L);
      empty_q <= (level_nxt == '0);
      valid_q <= (level_nxt != '0);
    end
  end

  // Overflow tracking; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q  <= 1'b1;
      if (ovf_clr)
        drop_q <= DROP_W'(1);
      else if (drop_q != '1)
        drop_q <= drop_q + DROP_W'(1);
    end else if (ovf_clr) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end
  end

  // Storage is deliberately left unreset; it is only visible through rd_valid
  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= bus.cap_data;
  end

`ifdef CAPTURE_BUFFER_TSTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] tmem [DEPTH];

  // Free-running cycle counter used to stamp accepted captures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ts_q <= '0;
    else
      ts_q <= ts_q + 16'd1;
  end

  // Timestamp storage written alongside the data byte
  always_ff @(posedge clk) begin
    if (wr)
      tmem[wptr] <= ts_q;
  end

  assign rd_tstamp = valid_q ? tmem[rptr] : 16'h0000;
`endif

  assign bus.rd_data  = valid_q ? mem[rptr] : 8'h00;
  assign bus.rd_valid = valid_q;
  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign ovf          = ovf_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - table-driven checks of capture_buffer (DEPTH=8, EDGE_MODE=1)
module tb_capture_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ovf_clr;
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic       ovf;
  logic [7:0] drop_cnt;
`ifdef CAPTURE_BUFFER_TSTAMP_EN
  logic [15:0] rd_tstamp;
`endif

  int tests = 0;
  int fails = 0;

  capture_buffer_if bus ();

  capture_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt)
`ifdef CAPTURE_BUFFER_TSTAMP_EN
    ,
    .rd_tstamp(rd_tstamp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       strb;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [7:0] d;
    logic [3:0] lvl;
    logic       f;
    logic       e;
    logic       o;
    logic [7:0] dc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic strb, logic [7:0] data, logic rdy, logic clr,
                              logic v, logic [7:0] d, logic [3:0] lvl, logic f,
                              logic o, logic [7:0] dc);
    vec_t r;
    r.strb = strb; r.data = data; r.rdy = rdy; r.clr = clr;
    r.v = v; r.d = d; r.lvl = lvl; r.f = f; r.e = (lvl == 4'd0); r.o = o; r.dc = dc;
    vecs.push_back(r);
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic v, logic [7:0] d, logic [3:0] lvl,
                           logic f, logic e, logic o, logic [7:0] dc);
    check({tag, " rd_valid"}, int'(bus.rd_valid), int'(v));
    check({tag, " rd_data"},  int'(bus.rd_data),  int'(d));
    check({tag, " level"},    int'(level),        int'(lvl));
    check({tag, " full"},     int'(full),         int'(f));
    check({tag, " empty"},    int'(empty),        int'(e));
    check({tag, " ovf"},      int'(ovf),          int'(o));
    check({tag, " drop_cnt"}, int'(drop_cnt),     int'(dc));
`ifdef CAPTURE_BUFFER_TSTAMP_EN
    if (!v) check({tag, " rd_tstamp"}, int'(rd_tstamp), 0);
`endif
  endtask

  // One strobe pulse: high for a cycle, then low for a cycle
  task automatic pulse(logic [7:0] data);
    @(negedge clk); bus.cap_strb = 1'b1; bus.cap_data = data;
    @(negedge clk); bus.cap_strb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bus.cap_strb = 1'b0; bus.cap_data = 8'h00; bus.rd_ready = 1'b0; ovf_clr = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    // Single capture, then pop
    add(1, 8'hA1, 0, 0, 1, 8'hA1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    // Strobe held high four cycles: only the rising edge captures
    add(1, 8'h3C, 0, 0, 1, 8'h3C, 1, 0, 0, 0);
    add(1, 8'h3C, 0, 0, 1, 8'h3C, 1, 0, 0, 0);
    add(1, 8'hFF, 0, 0, 1, 8'h3C, 1, 0, 0, 0);
    add(1, 8'hFF, 0, 0, 1, 8'h3C, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    // Fill 00..07
    for (int k = 0; k < 8; k++) begin
      add(1, 8'(k), 0, 0, 1, 8'h00, 4'(k + 1), (k == 7), 0, 0);
      add(0, 8'h00, 0, 0, 1, 8'h00, 4'(k + 1), (k == 7), 0, 0);
    end
    // Two drops while full
    add(1, 8'h55, 0, 0, 1, 8'h00, 8, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 8'h00, 8, 1, 1, 1);
    add(1, 8'h66, 0, 0, 1, 8'h00, 8, 1, 1, 2);
    add(0, 8'h00, 0, 0, 1, 8'h00, 8, 1, 1, 2);
    // Capture and pop together at full: no drop
    add(1, 8'h77, 1, 0, 1, 8'h01, 8, 1, 1, 2);
    add(0, 8'h00, 0, 0, 1, 8'h01, 8, 1, 1, 2);
    // Clear coinciding with a drop, then clear alone
    add(1, 8'h88, 0, 1, 1, 8'h01, 8, 1, 1, 1);
    add(0, 8'h00, 0, 1, 1, 8'h01, 8, 1, 0, 0);
    // Drain: 02..07 then 77 surface in order
    for (int k = 0; k < 8; k++)
      add(0, 8'h00, 1, 0, (k < 7), (k < 6) ? 8'(k + 2) : ((k == 6) ? 8'h77 : 8'h00),
          4'(7 - k), 0, 0, 0);

    repeat (3) @(posedge clk);
    #1 check_all("reset", 0, 8'h00, 0, 0, 1, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.cap_strb = vecs[i].strb; bus.cap_data = vecs[i].data;
      bus.rd_ready = vecs[i].rdy;  ovf_clr      = vecs[i].clr;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].lvl,
                vecs[i].f, vecs[i].e, vecs[i].o, vecs[i].dc);
    end

    // Refill across the pointer wrap, then drain with rd_ready held high
    @(negedge clk); bus.rd_ready = 1'b0; ovf_clr = 1'b0; bus.cap_strb = 1'b0;
    for (int k = 0; k < 8; k++) pulse(8'hD0 + 8'(k));
    check_all("refill", 1, 8'hD0, 8, 1, 0, 0, 0);
    @(negedge clk); bus.rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d rd_data", k), int'(bus.rd_data), 'hD0 + k);
      check($sformatf("drain%0d rd_valid", k), int'(bus.rd_valid), 1);
      @(posedge clk); #1;
    end
    check_all("drained", 0, 8'h00, 0, 0, 1, 0, 0);

    // Reset mid-drain, with the strobe held high across release
    @(negedge clk); bus.rd_ready = 1'b0;
    pulse(8'hE0); pulse(8'hE1); pulse(8'hE2);
    @(negedge clk); bus.rd_ready = 1'b1;
    @(posedge clk); #1;
    check_all("middrain", 1, 8'hE1, 2, 0, 0, 0, 0);
    @(negedge clk); bus.rd_ready = 1'b0; bus.cap_strb = 1'b1; bus.cap_data = 8'hF5;
    rst_n = 1'b0;
    #1 check_all("async_rst", 0, 8'h00, 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst_cap", 1, 8'hF5, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_all("post_rst_hold", 1, 8'hF5, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
